// File: rtl/i2c_master_core.sv
// Byte-level single-master I2C initiator: START / repeated START / STOP / WRITE / READ on open-drain SCL/SDA.
// Latency: START/STOP 4*CLK_DIV+3 cycles, WRITE/READ 9*(4*CLK_DIV+2)+1 cycles, illegal command 1 cycle; +1 per stretch cycle.
// Backpressure: cmd_ready_o is high only when idle; slave clock stretching stalls the released SCL phases.
module i2c_master_core #(
   parameter int   CLK_DIV          = 250,
   parameter logic SYNC_RESET_VALUE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [1:0] cmd_i,
   input  logic [7:0] data_i,
   input  logic       ack_i,
   output logic       done_o,
   output logic [7:0] data_o,
   output logic       ack_o,
   output logic       err_o,
   output logic       busy_o,
   output logic       bus_owned_o,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_oe_o,
   output logic       sda_oe_o
);

   localparam logic [1:0]  CMD_START = 2'b00;
   localparam logic [1:0]  CMD_STOP  = 2'b01;
   localparam logic [1:0]  CMD_WRITE = 2'b10;
   localparam logic [1:0]  CMD_READ  = 2'b11;
   // Ordinary phases count CLK_DIV cycles; released phases get two extra
   // counts so the synchronizer latency is absorbed before stretching is honoured.
   localparam logic [16:0] DIV_M1    = 17'(CLK_DIV - 1);
   localparam logic [16:0] DIV_P1    = 17'(CLK_DIV + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cmd_q, cmd_d;
   logic [1:0]  ph_q, ph_d;
   logic [3:0]  cell_q, cell_d;
   logic [16:0] cnt_q, cnt_d;
   logic [7:0]  wdat_q, wdat_d;
   logic        ackin_q, ackin_d;
   logic [7:0]  rx_q, rx_d;
   logic        acks_q, acks_d;
   logic        errp_q, errp_d;
   logic        scl_oe_q, scl_oe_d;
   logic        sda_oe_q, sda_oe_d;
   logic        done_q, done_d;
   logic [7:0]  data_q, data_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        owned_q, owned_d;
   logic        scl_m_q, scl_s_q, sda_m_q, sda_s_q;
   logic        enter, tick, bit_v;

   // START/STOP release SCL in phase 1; bit cells release it in quarter 2.
   function automatic logic rel_phase(input logic [1:0] c, input logic [1:0] p);
      return c[1] ? (p == 2'd2) : (p == 2'd1);
   endfunction

   // Two-flop synchronizers for the asynchronous bus lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_m_q <= SYNC_RESET_VALUE;
         scl_s_q <= SYNC_RESET_VALUE;
         sda_m_q <= SYNC_RESET_VALUE;
         sda_s_q <= SYNC_RESET_VALUE;
      end else begin
         scl_m_q <= scl_i;
         scl_s_q <= scl_m_q;
         sda_m_q <= sda_i;
         sda_s_q <= sda_m_q;
      end
   end

   // Command sequencer: phase timing, bit shifting, line drive and completion.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      ph_d     = ph_q;
      cell_d   = cell_q;
      cnt_d    = cnt_q;
      wdat_d   = wdat_q;
      ackin_d  = ackin_q;
      rx_d     = rx_q;
      acks_d   = acks_q;
      errp_d   = errp_q;
      scl_oe_d = scl_oe_q;
      sda_oe_d = sda_oe_q;
      done_d   = 1'b0;
      data_d   = data_q;
      ack_d    = ack_q;
      err_d    = err_q;
      owned_d  = owned_q;
      enter    = 1'b0;
      tick     = 1'b0;
      bit_v    = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               cmd_d   = cmd_i;
               wdat_d  = data_i;
               ackin_d = ack_i;
               ph_d    = 2'd0;
               cell_d  = 4'd0;
               cnt_d   = DIV_M1;
               if ((cmd_i != CMD_START) && !owned_q) begin
                  // Not owning the bus: complete at once with an error, lines untouched.
                  errp_d  = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  errp_d  = 1'b0;
                  state_d = ST_RUN;
                  enter   = 1'b1;
               end
            end
         end
         ST_RUN: begin
            tick = !rel_phase(cmd_q, ph_q) || scl_s_q || (cnt_q > DIV_M1);
            // First cycle of the SCL-high quarter: take the bit.
            if (cmd_q[1] && (ph_q == 2'd3) && (cnt_q == DIV_M1)) begin
               if (cell_q == 4'd8) acks_d = sda_s_q;
               else                rx_d   = {rx_q[6:0], sda_s_q};
            end
            if (tick) begin
               if (cnt_q != 17'd0) begin
                  cnt_d = cnt_q - 17'd1;
               end else if ((ph_q == 2'd3) && (!cmd_q[1] || (cell_q == 4'd8))) begin
                  state_d = ST_FIN;
                  if (cmd_q[1]) scl_oe_d = 1'b1;
               end else begin
                  ph_d = ph_q + 2'd1;
                  if (ph_q == 2'd3) begin
                     cell_d = cell_q + 4'd1;
                     wdat_d = {wdat_q[6:0], 1'b0};
                  end
                  cnt_d = rel_phase(cmd_q, ph_d) ? DIV_P1 : DIV_M1;
                  enter = 1'b1;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = errp_q;
            if (!errp_q) begin
               case (cmd_q)
                  CMD_START: owned_d = 1'b1;
                  CMD_STOP:  owned_d = 1'b0;
                  CMD_WRITE: ack_d   = acks_q;
                  default:   data_d  = rx_q;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line levels are set once, on entry to each phase.
      if (enter) begin
         if (cell_d == 4'd8) bit_v = (cmd_d == CMD_READ) ? ackin_d : 1'b1;
         else                bit_v = (cmd_d == CMD_WRITE) ? wdat_d[7] : 1'b1;
         case (cmd_d)
            CMD_START: begin
               case (ph_d)
                  2'd0:    sda_oe_d = 1'b0;
                  2'd1:    scl_oe_d = 1'b0;
                  2'd2:    sda_oe_d = 1'b1;
                  default: scl_oe_d = 1'b1;
               endcase
            end
            CMD_STOP: begin
               case (ph_d)
                  2'd0: begin
                     sda_oe_d = 1'b1;
                     scl_oe_d = 1'b1;
                  end
                  2'd1:    scl_oe_d = 1'b0;
                  2'd2:    sda_oe_d = 1'b0;
                  default: ;
               endcase
            end
            default: begin
               case (ph_d)
                  2'd0: begin
                     scl_oe_d = 1'b1;
                     sda_oe_d = ~bit_v;
                  end
                  2'd1:    scl_oe_d = 1'b1;
                  2'd2:    scl_oe_d = 1'b0;
                  default: ;
               endcase
            end
         endcase
      end
   end

   // State and output registers; reset releases both lines immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cmd_q    <= CMD_START;
         ph_q     <= 2'd0;
         cell_q   <= 4'd0;
         cnt_q    <= 17'd0;
         wdat_q   <= 8'd0;
         ackin_q  <= 1'b0;
         rx_q     <= 8'd0;
         acks_q   <= 1'b0;
         errp_q   <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
         done_q   <= 1'b0;
         data_q   <= 8'd0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         owned_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         ph_q     <= ph_d;
         cell_q   <= cell_d;
         cnt_q    <= cnt_d;
         wdat_q   <= wdat_d;
         ackin_q  <= ackin_d;
         rx_q     <= rx_d;
         acks_q   <= acks_d;
         errp_q   <= errp_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
         done_q   <= done_d;
         data_q   <= data_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         owned_q  <= owned_d;
      end
   end

   assign cmd_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign data_o      = data_q;
   assign ack_o       = ack_q;
   assign err_o       = err_q;
   assign bus_owned_o = owned_q;
   assign scl_oe_o    = scl_oe_q;
   assign sda_oe_o    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Scoreboard bench for i2c_master_core with an ideal pull-up bus and a small slave model.
module tb_i2c_master_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [1:0] cmd_i = 2'b00;
   logic [7:0] data_i = 8'h00;
   logic       ack_i = 1'b0;
   logic       done_o;
   logic [7:0] data_o;
   logic       ack_o, err_o, busy_o, bus_owned_o;
   logic       scl_i, sda_i, scl_oe_o, sda_oe_o;

   logic       slv_low = 1'b0;
   logic       stretch = 1'b0;

   assign scl_i = ~scl_oe_o & ~stretch;
   assign sda_i = ~sda_oe_o & ~slv_low;

   always #5 clk = ~clk;

   i2c_master_core #(.CLK_DIV(4), .SYNC_RESET_VALUE(1'b1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i),
      .data_i(data_i), .ack_i(ack_i),
      .done_o(done_o), .data_o(data_o), .ack_o(ack_o), .err_o(err_o),
      .busy_o(busy_o), .bus_owned_o(bus_owned_o),
      .scl_i(scl_i), .sda_i(sda_i), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o)
   );

   typedef struct {
      string      name;
      int         acc;
      int         lat;
      logic       err;
      logic       owned;
      logic       chk_d;
      logic [7:0] d;
      logic       chk_a;
      logic       a;
   } exp_t;

   exp_t       sbq[$];
   int         cyc = 0;
   int         nvec = 0;
   int         nerr = 0;
   int         falls = 0;
   int         slv_base = 0;
   logic [1:0] slv_mode = 2'd0;
   logic [7:0] slv_byte = 8'h00;
   logic [8:0] rec = 9'd0;
   int         start_seen = 0;
   int         stop_seen = 0;
   logic       scl_prev = 1'b1;
   logic       sda_prev = 1'b1;
   logic       ill_watch = 1'b0, ill_oe = 1'b0;
   logic       rd_watch = 1'b0, rd_oe = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input string nm, input logic [1:0] c, input logic [7:0] d, input logic a,
                        input bit push, input int lat, input logic e_err, input logic e_own,
                        input logic cd, input logic [7:0] ed, input logic ca, input logic ea);
      int   n;
      exp_t x;
      n = 0;
      @(negedge clk);
      while (!cmd_ready_o && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready_o) begin
         check({nm, "_ready"}, cmd_ready_o, 1);
         return;
      end
      cmd_valid_i = 1'b1;
      cmd_i       = c;
      data_i      = d;
      ack_i       = a;
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      if (push) begin
         x.name = nm; x.acc = cyc; x.lat = lat; x.err = e_err; x.owned = e_own;
         x.chk_d = cd; x.d = ed; x.chk_a = ca; x.a = ea;
         sbq.push_back(x);
      end
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL %s_timeout: actual pending %0d required 0", nm, sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      int   n;
      int   cnt;
      logic prev;
      logic sda_ref;
      logic chg;

      fork
         forever begin
            @(posedge clk);
            cyc++;
         end
         begin : mon
            int         idx;
            logic [7:0] sh;
            exp_t       x;
            forever begin
               @(negedge clk);
               if (scl_prev && scl_i && sda_prev && !sda_i) start_seen++;
               if (scl_prev && scl_i && !sda_prev && sda_i) stop_seen++;
               if (scl_prev && !scl_i) falls++;
               if (!scl_prev && scl_i) rec = {rec[7:0], sda_i};
               scl_prev = scl_i;
               sda_prev = sda_i;
               idx = falls - slv_base;
               sh  = slv_byte << idx;
               case (slv_mode)
                  2'd1:    slv_low = (idx == 8);
                  2'd2:    slv_low = (idx < 8) && !sh[7];
                  default: slv_low = 1'b0;
               endcase
               if (ill_watch && (scl_oe_o || sda_oe_o)) ill_oe = 1'b1;
               if (rd_watch && (idx == 8) && sda_oe_o) rd_oe = 1'b1;
               if (done_o) begin
                  if (sbq.size() == 0) begin
                     check("unexpected_done", done_o, 0);
                  end else begin
                     x = sbq.pop_front();
                     check({x.name, "_latency"}, cyc - x.acc, x.lat);
                     check({x.name, "_err"}, err_o, x.err);
                     check({x.name, "_owned"}, bus_owned_o, x.owned);
                     check({x.name, "_ready"}, cmd_ready_o, 1);
                     check({x.name, "_busy"}, busy_o, 0);
                     if (x.chk_d) check({x.name, "_data"}, data_o, x.d);
                     if (x.chk_a) check({x.name, "_ack"}, ack_o, x.a);
                  end
               end
            end
         end
      join_none

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_scl_oe", scl_oe_o, 0);
      check("rst_sda_oe", sda_oe_o, 0);
      check("rst_done", done_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_owned", bus_owned_o, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", cmd_ready_o, 1);
      check("rst_data", data_o, 0);
      check("rst_ack", ack_o, 0);
      check("rst_err", err_o, 0);

      // WRITE without owning the bus
      ill_watch = 1'b1;
      issue("ill_write", 2'b10, 8'h5A, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_done("ill_write");
      repeat (4) @(negedge clk);
      ill_watch = 1'b0;
      check("ill_lines_quiet", ill_oe, 0);

      // START
      issue("start", 2'b00, 8'h00, 1'b0, 1'b1, 19, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_done("start");
      check("start_cond", start_seen, 1);

      // WRITE 0xA5, slave ACKs
      slv_base = falls; slv_mode = 2'd1;
      issue("wr_a5", 2'b10, 8'hA5, 1'b0, 1'b1, 163, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      wait_done("wr_a5");
      check("wr_a5_bus_bits", rec[8:1], 8'hA5);
      check("wr_a5_bus_ack", rec[0], 0);

      // READ 0x3C, master NACKs
      slv_base = falls; slv_mode = 2'd2; slv_byte = 8'h3C; rd_watch = 1'b1;
      issue("rd_3c", 2'b11, 8'h00, 1'b1, 1'b1, 163, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      wait_done("rd_3c");
      rd_watch = 1'b0;
      check("rd_ack_cell_released", rd_oe, 0);
      check("rd_bus_nack", rec[0], 1);

      // WRITE 0x5A with the slave stretching SCL by 20 cycles in bit 3
      slv_base = falls; slv_mode = 2'd1;
      issue("wr_stretch", 2'b10, 8'h5A, 1'b0, 1'b1, 183, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      prev = scl_oe_o; cnt = 0; n = 0;
      while (cnt < 5 && n < 2000) begin
         @(posedge clk); #1;
         if (prev && !scl_oe_o) cnt++;
         prev = scl_oe_o;
         n++;
      end
      check("stretch_bit3_found", cnt, 5);
      stretch = 1'b1;
      sda_ref = sda_oe_o;
      chg = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (sda_oe_o !== sda_ref) chg = 1'b1;
      end
      stretch = 1'b0;
      check("stretch_sda_hold", chg, 0);
      wait_done("wr_stretch");
      check("stretch_bus_bits", rec[8:1], 8'h5A);

      // STOP
      slv_mode = 2'd0;
      issue("stop", 2'b01, 8'h00, 1'b0, 1'b1, 19, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_done("stop");
      check("stop_cond", stop_seen, 1);
      check("stop_scl_released", scl_oe_o, 0);
      check("stop_sda_released", sda_oe_o, 0);

      // Reset in the middle of bit 5 of a WRITE
      issue("start2", 2'b00, 8'h00, 1'b0, 1'b1, 19, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      wait_done("start2");
      slv_base = falls; slv_mode = 2'd1;
      issue("wr_abort", 2'b10, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      prev = scl_oe_o; cnt = 0; n = 0;
      while (cnt < 2 && n < 2000) begin
         @(posedge clk); #1;
         if (!prev && scl_oe_o) cnt++;
         prev = scl_oe_o;
         n++;
      end
      check("abort_bit5_found", cnt, 2);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("abort_pre_scl_low", scl_oe_o, 1);
      check("abort_pre_sda_low", sda_oe_o, 1);
      #2 rst = 1'b1;
      #1;
      check("abort_scl_released", scl_oe_o, 0);
      check("abort_sda_released", sda_oe_o, 0);
      slv_mode = 2'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", cmd_ready_o, 1);
      check("abort_owned", bus_owned_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_data_cleared", data_o, 0);
      repeat (5) @(negedge clk);
      check("sb_drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
- Byte-level I2C initiator: executes START, repeated START, STOP, WRITE-byte and READ-byte commands on an open-drain SCL/SDA pair.
- Used as the bus driver for the slave design in system and testbench contexts. It is the controller side of the same bus.
- Samples bus lines through internal 2-FF synchronizers. Honours slave clock stretching.
- Single-master only: no arbitration and no multi-master detection.

Parameters:
CLK_DIV, 250, clk cycles per quarter SCL period (SCL ≈ f_clk/(4*CLK_DIV)); legal range 2..65535
SYNC_RESET_VALUE, 1'b1, reset value of the SCL/SDA synchronizer stages (idle bus level)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cmd_valid_i  input  1  command request
cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o at posedge clk
cmd_i  input  2  00=START, 01=STOP, 10=WRITE, 11=READ
data_i  input  8  WRITE byte, MSB first; captured on acceptance
ack_i  input  1  READ: level master drives in the 9th bit (0=ACK, 1=NACK); captured on acceptance
done_o  output  1  one-cycle pulse when a command completes
data_o  output  8  READ result; valid with done_o, held until next READ done
ack_o  output  1  WRITE: sampled slave ACK bit (0=ACK); valid with done_o, held
err_o  output  1  with done_o: command was illegal; held until next done_o
busy_o  output  1  command in progress
bus_owned_o  output  1  high from START done to STOP done
scl_i  input  1  asynchronous SCL line level
sda_i  input  1  asynchronous SDA line level
scl_oe_o  output  1  1 = pull SCL low, 0 = release
sda_oe_o  output  1  1 = pull SDA low, 0 = release

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: scl_oe_o=0, sda_oe_o=0, done_o=0, data_o=0, ack_o=0, err_o=0, busy_o=0, bus_owned_o=0, synchronizers=SYNC_RESET_VALUE.
- After reset: cmd_ready_o=1 (IDLE).
- Reset mid-command: both lines are released immediately (asynchronously). The command is abandoned, no done_o is issued, and bus_owned_o is cleared.
- All outputs are registered.
- scl_s and sda_s are the 2-FF synchronized versions of scl_i and sda_i.

Handshake:
- cmd_ready_o=1 only in IDLE.
- Acceptance sets busy_o=1 and drops cmd_ready_o in the next cycle.
- In the cycle done_o pulses, busy_o=0 and cmd_ready_o=1. A new command can therefore be accepted in the same cycle as done_o.

Illegal commands:
- WRITE, READ or STOP while bus_owned_o=0.
- Response: done_o and err_o=1 exactly 1 cycle after acceptance.
- scl_oe_o and sda_oe_o do not change.

Phases:
- Every command is a sequence of quarter phases, each CLK_DIV cycles, timed by a down-counter.
- Released phases are phases where SCL is released. In these, the counter only decrements on cycles with scl_s=1. This implements clock stretching and needs no timeout.
- On an ideal bus (pull-up is instant), each released phase lasts CLK_DIV+2 cycles because of synchronizer latency.

START (also repeated START when bus_owned_o=1):
- P0: release SDA, SCL unchanged.
- P1: release SCL (released phase).
- P2: SDA low.
- P3: SCL low.
- At done: bus_owned_o=1.

STOP:
- P0: SDA low, SCL low.
- P1: release SCL (released phase).
- P2: release SDA.
- P3: hold.
- At done: bus_owned_o=0; both lines released.

Bit cell (WRITE/READ, 9 cells per byte, bits 7..0 then the ACK cell):
- Q0: SCL low, drive SDA with the bit (sda_oe_o = ~bit).
- Q1: SCL low.
- Q2: release SCL (released phase).
- Q3: SCL high. sda_s is sampled on the first cycle of Q3.
- WRITE: the ACK cell releases SDA; its sample goes to ack_o.
- READ: data cells release SDA; samples shift into data_o MSB-first. The ACK cell drives ack_i.
- After Q3 of the last cell, SCL is pulled low, and data_o/ack_o update with done_o.

Latency from acceptance edge to done_o, ideal bus:
- START and STOP: 4*CLK_DIV+2+1 cycles.
- WRITE and READ: 9*(4*CLK_DIV+2)+1 cycles.
- Each stretch cycle adds 1.

Test Plan:
- CLK_DIV=4, ideal pull-up bus. START: SDA falls while SCL high; done_o 19 cycles after acceptance; bus_owned_o=1.
- Once bus_owned_o=1, WRITE data_i=0xA5 with slave model ACKing: SDA during SCL-high reads 1,0,1,0,0,1,0,1; ack_o=0; done_o 163 cycles after acceptance.
- READ, slave drives 0x3C, ack_i=1: data_o=0x3C; sda_oe_o=0 throughout the 9th cell; done_o 163 cycles after acceptance.
- Slave holds scl_i low 20 extra cycles during bit 3 of a WRITE: done_o arrives 183 cycles after acceptance; no SDA change while SCL is held low by the slave.
- WRITE immediately after reset (no START): done_o and err_o=1 one cycle after acceptance; scl_oe_o=sda_oe_o=0 throughout. Then STOP after START: SDA rises while SCL high; bus_owned_o=0.
- Assert rst during bit 5 of a WRITE: scl_oe_o and sda_oe_o go to 0 before the next clk edge; no done_o; cmd_ready_o=1 after rst is released.
